// File: rtl/thistle_pkg.sv
// Shared definitions for the Thistle 8-bit CPU fetch front end.
//   FETCH_ADDR_W   : default PC/MAR width (RAM depth 2^FETCH_ADDR_W)
//   FETCH_DATA_W   : default bus/instruction width
//   FETCH_RESET_PC : default PC value after reset
//   fetch_state_t  : fetch FSM states (RUN, HALT)
package thistle_pkg;

  localparam int unsigned FETCH_ADDR_W   = 4;
  localparam int unsigned FETCH_DATA_W   = 8;
  localparam int unsigned FETCH_RESET_PC = 0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Decoder <-> fetch unit connection: shared bus, decoder strobes and the
// fetch unit's status/result outputs.
//   master : decoder/bus side (drives bus_in and strobes)
//   slave  : fetch_unit side (drives bus_out, bus_oe, mar, inst, ir_en,
//            pc_wrap, halted)
interface fetch_unit_if
  import thistle_pkg::*;
#(
  parameter int unsigned ADDR_W = FETCH_ADDR_W,
  parameter int unsigned DATA_W = FETCH_DATA_W
);

  logic [DATA_W-1:0] bus_in;
  logic              hlt;
  logic              pe;
  logic              pi;
  logic              po;
  logic              mi;
  logic              ii;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] inst;
  logic              ir_en;
  logic              pc_wrap;
  logic              halted;

  modport master (
    output bus_in, hlt, pe, pi, po, mi, ii,
    input  bus_out, bus_oe, mar, inst, ir_en, pc_wrap, halted
  );

  modport slave (
    input  bus_in, hlt, pe, pi, po, mi, ii,
    output bus_out, bus_oe, mar, inst, ir_en, pc_wrap, halted
  );

endinterface

// File: rtl/pc_counter.sv
// Program counter for the Thistle fetch unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : update enable (fetch FSM in RUN)
//   pe         : count enable
//   pi         : load from load_val (wins over pe)
//   load_val   : value loaded when pi=1
//   pc         : current program counter
//   wrap_q     : registered pulse, high the cycle after PC wraps all-ones -> 0
module pc_counter #(
  parameter int unsigned       ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              pe,
  input  logic              pi,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc,
  output logic              wrap_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      wrap_q <= 1'b0;
    end else begin
      // A load on the same edge suppresses the wrap even at all-ones.
      wrap_q <= en & pe & ~pi & (pc == '1);
      if (en) begin
        if (pi) begin
          pc <= load_val;
        end else if (pe) begin
          pc <= pc + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end of the Thistle 8-bit CPU (upstream of
// inst_decoder). Holds PC (via pc_counter), MAR and IR, obeys the decoder's
// PE/PI/PO/MI/II/HLT strobes and returns the opcode as inst with an ir_en
// strobe.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   fif  : fetch_unit_if.slave (bus_in, strobes in; bus_out, bus_oe, mar,
//          inst, ir_en, pc_wrap, halted out)
// Optional feature macro FETCH_BKPT_EN adds bkpt_addr/bkpt_arm inputs and a
// sticky bkpt_hit output: an armed MAR load matching bkpt_addr halts the unit.
module fetch_unit
  import thistle_pkg::*;
#(
  parameter int unsigned ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned DATA_W   = FETCH_DATA_W,
  parameter int unsigned RESET_PC = FETCH_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FETCH_BKPT_EN
  input  logic [ADDR_W-1:0] bkpt_addr,
  input  logic              bkpt_arm,
  output logic              bkpt_hit,
`endif
  fetch_unit_if.slave       fif
);

  fetch_state_t      state_q, state_d;
  logic              run;
  logic              halt_req;
  logic [ADDR_W-1:0] pc;
  logic              wrap_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] ir_q;
  logic              ir_en_q;

  assign run = (state_q == RUN);

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (ADDR_W'(RESET_PC))
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst),
    .en       (run),
    .pe       (fif.pe),
    .pi       (fif.pi),
    .load_val (fif.bus_in[ADDR_W-1:0]),
    .pc       (pc),
    .wrap_q   (wrap_q)
  );

`ifdef FETCH_BKPT_EN
  logic bkpt_match;
  logic bkpt_hit_q;

  assign bkpt_match = run & bkpt_arm & fif.mi &
                      (fif.bus_in[ADDR_W-1:0] == bkpt_addr);
  assign halt_req   = fif.hlt | bkpt_match;
  assign bkpt_hit   = bkpt_hit_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bkpt_hit_q <= 1'b0;
    end else if (bkpt_match) begin
      bkpt_hit_q <= 1'b1;
    end
  end
`else
  assign halt_req = fif.hlt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // Strobes seen on the halting edge still take effect; the freeze applies
  // from the following edge because run is derived from the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mar_q   <= '0;
      ir_q    <= '0;
      ir_en_q <= 1'b0;
    end else begin
      ir_en_q <= run & fif.ii;
      if (run && fif.mi) mar_q <= fif.bus_in[ADDR_W-1:0];
      if (run && fif.ii) ir_q  <= fif.bus_in;
    end
  end

  // Registered pulses are masked by state so an IR load or PC wrap on the
  // halting edge does not leak a strobe into HALT.
  always_comb begin
    fif.bus_oe  = fif.po & run & rst;
    fif.bus_out = fif.bus_oe ? DATA_W'(pc) : '0;
    fif.mar     = mar_q;
    fif.inst    = ir_q;
    fif.ir_en   = ir_en_q & run;
    fif.pc_wrap = wrap_q & run;
    fif.halted  = ~run;
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(4), .DATA_W(8)) fif ();

`ifdef FETCH_BKPT_EN
  logic [3:0] bkpt_addr;
  logic       bkpt_arm;
  logic       bkpt_hit;
`endif

  fetch_unit #(
    .ADDR_W   (4),
    .DATA_W   (8),
    .RESET_PC (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FETCH_BKPT_EN
    .bkpt_addr (bkpt_addr),
    .bkpt_arm  (bkpt_arm),
    .bkpt_hit  (bkpt_hit),
`endif
    .fif       (fif)
  );

  // strb = {pe, pi, po, mi, ii, hlt}; flg = {bus_oe, ir_en, pc_wrap, halted}
  typedef struct {
    logic [5:0] strb;
    logic [7:0] bus;
    logic [7:0] bo;
    logic [3:0] mar;
    logic [7:0] inst;
    logic [3:0] flg;
  } vec_t;

  typedef struct {
    logic [7:0] bo;
    logic [3:0] mar;
    logic [7:0] inst;
    logic [3:0] flg;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input int unsigned idx,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] s, input logic [7:0] b);
    fif.pe     = s[5];
    fif.pi     = s[4];
    fif.po     = s[3];
    fif.mi     = s[2];
    fif.ii     = s[1];
    fif.hlt    = s[0];
    fif.bus_in = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int unsigned idx, input exp_t e);
    chk({tag, ".bus_out"}, idx, 32'(fif.bus_out), 32'(e.bo));
    chk({tag, ".bus_oe"},  idx, 32'(fif.bus_oe),  32'(e.flg[3]));
    chk({tag, ".mar"},     idx, 32'(fif.mar),     32'(e.mar));
    chk({tag, ".inst"},    idx, 32'(fif.inst),    32'(e.inst));
    chk({tag, ".ir_en"},   idx, 32'(fif.ir_en),   32'(e.flg[2]));
    chk({tag, ".pc_wrap"}, idx, 32'(fif.pc_wrap), 32'(e.flg[1]));
    chk({tag, ".halted"},  idx, 32'(fif.halted),  32'(e.flg[0]));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    exp_t e;

    // Expected outputs sampled just after the edge that consumed the vector.
    //              strb       bus    bus_out mar    inst   flg
    vecs.push_back('{6'b100000, 8'h00, 8'h00, 4'h0, 8'h00, 4'b0000}); // PC 1
    vecs.push_back('{6'b100000, 8'h00, 8'h00, 4'h0, 8'h00, 4'b0000}); // PC 2
    vecs.push_back('{6'b101000, 8'h00, 8'h03, 4'h0, 8'h00, 4'b1000}); // PC 3
    vecs.push_back('{6'b001000, 8'h00, 8'h03, 4'h0, 8'h00, 4'b1000});
    vecs.push_back('{6'b000010, 8'hB0, 8'h00, 4'h0, 8'hB0, 4'b0100});
    vecs.push_back('{6'b000000, 8'h00, 8'h00, 4'h0, 8'hB0, 4'b0000});
    vecs.push_back('{6'b000010, 8'h11, 8'h00, 4'h0, 8'h11, 4'b0100});
    vecs.push_back('{6'b000010, 8'h22, 8'h00, 4'h0, 8'h22, 4'b0100});
    vecs.push_back('{6'b000100, 8'h0A, 8'h00, 4'hA, 8'h22, 4'b0000});
    vecs.push_back('{6'b000110, 8'h3C, 8'h00, 4'hC, 8'h3C, 4'b0100});
    vecs.push_back('{6'b011000, 8'h0E, 8'h0E, 4'hC, 8'h3C, 4'b1000}); // PC E
    vecs.push_back('{6'b101000, 8'h00, 8'h0F, 4'hC, 8'h3C, 4'b1000}); // PC F
    vecs.push_back('{6'b100000, 8'h00, 8'h00, 4'hC, 8'h3C, 4'b0010}); // wrap
    vecs.push_back('{6'b001000, 8'h00, 8'h00, 4'hC, 8'h3C, 4'b1000});
    vecs.push_back('{6'b111000, 8'h07, 8'h07, 4'hC, 8'h3C, 4'b1000}); // pi wins
    vecs.push_back('{6'b010000, 8'h0F, 8'h00, 4'hC, 8'h3C, 4'b0000}); // PC F
    vecs.push_back('{6'b111000, 8'h02, 8'h02, 4'hC, 8'h3C, 4'b1000}); // no wrap
    vecs.push_back('{6'b000101, 8'h05, 8'h00, 4'h5, 8'h3C, 4'b0001}); // halt
    vecs.push_back('{6'b101010, 8'h77, 8'h00, 4'h5, 8'h3C, 4'b0001});
    vecs.push_back('{6'b111100, 8'h0F, 8'h00, 4'h5, 8'h3C, 4'b0001});
    vecs.push_back('{6'b000000, 8'h00, 8'h00, 4'h5, 8'h3C, 4'b0001});

    drive(6'b001000, 8'h00);
`ifdef FETCH_BKPT_EN
    bkpt_addr = 4'h0;
    bkpt_arm  = 1'b0;
`endif
    rst = 1'b0;
    #2;
    e = '{8'h00, 4'h0, 8'h00, 4'b0000};
    chk_out("reset", 0, e);
    step();
    step();
    rst = 1'b1;
    drive(6'b000000, 8'h00);

    foreach (vecs[i]) begin
      drive(vecs[i].strb, vecs[i].bus);
      exp_q.push_back('{vecs[i].bo, vecs[i].mar, vecs[i].inst, vecs[i].flg});
      step();
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_out("vec", i, e);
      end
    end

    // Asynchronous reset aborts a pending ir_en and clears halt.
    drive(6'b000000, 8'h00);
    do_reset();
    chk("rst_halt.halted", 0, 32'(fif.halted), 32'd0);
    drive(6'b010000, 8'h0A);
    step();
    drive(6'b000010, 8'hB0);
    step();
    chk("abort.inst_pre", 0, 32'(fif.inst), 32'hB0);
    chk("abort.ir_en_pre", 0, 32'(fif.ir_en), 32'd1);
    drive(6'b000010, 8'hC3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.inst", 0, 32'(fif.inst), 32'h00);
    chk("abort.ir_en", 0, 32'(fif.ir_en), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("abort.ir_en_hold", k, 32'(fif.ir_en), 32'd0);
      chk("abort.halted", k, 32'(fif.halted), 32'd0);
    end
    drive(6'b001000, 8'h00);
    rst = 1'b1;
    #1;
    chk("abort.pc_reset", 0, 32'(fif.bus_out), 32'h00);
    chk("abort.bus_oe", 0, 32'(fif.bus_oe), 32'd1);
    step();
    chk("abort.ir_en_after", 0, 32'(fif.ir_en), 32'd0);

    // IR load on the halting edge: inst updates, no ir_en in HALT.
    drive(6'b000011, 8'h5A);
    step();
    chk("hlt_ii.inst", 0, 32'(fif.inst), 32'h5A);
    chk("hlt_ii.ir_en", 0, 32'(fif.ir_en), 32'd0);
    chk("hlt_ii.halted", 0, 32'(fif.halted), 32'd1);
    drive(6'b000000, 8'h00);

`ifdef FETCH_BKPT_EN
    do_reset();
    bkpt_arm  = 1'b1;
    bkpt_addr = 4'h9;
    drive(6'b000100, 8'h08);
    step();
    chk("bkpt_miss.mar", 0, 32'(fif.mar), 32'h8);
    chk("bkpt_miss.halted", 0, 32'(fif.halted), 32'd0);
    drive(6'b000100, 8'h09);
    step();
    chk("bkpt.mar", 0, 32'(fif.mar), 32'h9);
    chk("bkpt.halted", 0, 32'(fif.halted), 32'd1);
    chk("bkpt.hit", 0, 32'(bkpt_hit), 32'd1);
    drive(6'b000000, 8'h00);
    do_reset();
    chk("bkpt.hit_clr", 0, 32'(bkpt_hit), 32'd0);
    bkpt_arm = 1'b0;
    drive(6'b000100, 8'h09);
    step();
    chk("bkpt_off.mar", 0, 32'(fif.mar), 32'h9);
    chk("bkpt_off.halted", 0, 32'(fif.halted), 32'd0);
    chk("bkpt_off.hit", 0, 32'(bkpt_hit), 32'd0);
    drive(6'b000000, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end of the Thistle 8-bit CPU, directly upstream of inst_decoder.
- Holds the program counter (PC), the memory address register (MAR) and the instruction register (IR).
- Obeys the decoder's PE/PI/PO/MI/II/HLT strobes.
- Returns the fetched opcode as inst with a one-cycle ir_en strobe, which the decoder consumes.

Parameters:
ADDR_W, 4, width of PC and MAR (RAM depth 2^ADDR_W)
DATA_W, 8, bus and instruction width
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
bus_in  input  DATA_W  shared data bus as seen by this block
hlt  input  1  HLT strobe from decoder
pe  input  1  PC count enable
pi  input  1  PC load from bus
po  input  1  PC drive onto bus
mi  input  1  MAR load from bus
ii  input  1  IR load from bus
bus_out  output  DATA_W  zero-extended PC when po asserted, else 0
bus_oe  output  1  bus drive enable (equals po while running)
mar  output  ADDR_W  RAM address
inst  output  DATA_W  IR contents, to decoder
ir_en  output  1  one-cycle strobe: new inst valid
pc_wrap  output  1  one-cycle pulse when PC increments from all-ones to 0
halted  output  1  sticky halt status

Behaviour:
Reset (rst=0, asynchronous):
- PC=RESET_PC; MAR=0; IR=0; ir_en=0; pc_wrap=0; halted=0; state=RUN.
- bus_out=0 and bus_oe=0 while in reset.
- Reset asserted mid-operation aborts any pending ir_en.

State machine has two states, RUN and HALT.
- RUN→HALT on a clk edge with hlt=1.
- HALT persists until reset; no other exit.
- halted=1 exactly in HALT.
- In HALT all register updates are inhibited, bus_oe=0, ir_en=0 and pc_wrap=0.
- hlt asserted in the same cycle as other strobes: those strobes still take effect on that edge; the freeze starts from the next edge.

PC rules (RUN only, evaluated per edge):
- pi=1: PC <= bus_in[ADDR_W-1:0]. pi has priority over pe; a simultaneous pe is ignored.
- else pe=1: PC <= PC+1 modulo 2^ADDR_W.
- On wrap (PC all-ones with pe=1 and pi=0), pc_wrap=1 for the following cycle only.

Bus output (combinational):
- bus_out = {zeros, PC} when po=1 and state=RUN; else 0.
- bus_oe = po & RUN.
- po=1 together with pi=1 drives the old PC and loads bus_in on the edge; the block does not check for this.

MAR: mi=1 gives MAR <= bus_in[ADDR_W-1:0], with a one-edge latency.

IR and ir_en:
- ii=1 gives IR <= bus_in.
- ir_en is registered and equals 1 in the cycle after each edge that loaded IR.
- Back-to-back ii produces back-to-back ir_en.
- inst holds its value between loads.

Simultaneous mi and ii both load the same bus_in value, each into its own register.

Optional Feature:
FETCH_BKPT_EN
- Defined: adds inputs bkpt_addr[ADDR_W] and bkpt_arm[1], and output bkpt_hit[1].
  - While bkpt_arm=1, an mi load whose value equals bkpt_addr forces RUN→HALT on the next edge.
  - bkpt_hit=1 (sticky until reset) identifies the halt cause.
  - The MAR load itself completes.
- Undefined: these ports and the logic are absent; HALT is reached only via hlt.

Decomposition:
- Package thistle_pkg holds:
  - ADDR_W and DATA_W defaults
  - fetch_state_t enum {RUN, HALT}
  - RESET_PC constant
- One sub-module, pc_counter, covers the PC register, load/increment priority and the pc_wrap pulse.
- fetch_unit instantiates pc_counter and owns MAR, IR, ir_en, bus_out and the state machine.

Test Plan:
1. Reset then pe for 3 cycles → PC 0,1,2,3; po=1 → bus_out=8'h03, bus_oe=1.
2. bus_in=8'hB0 with ii=1 for one cycle → next cycle inst=8'hB0, ir_en=1; the cycle after, ir_en=0 with inst still 8'hB0.
3. PC=4'hF, pe=1 → PC=0 and pc_wrap=1 for exactly one cycle. Then pi=1 and pe=1 with bus_in=8'h07 → PC=7 (load wins).
4. hlt=1 together with mi=1 and bus_in=8'h05 → MAR=5 and halted=1. Afterwards pe, ii and po have no effect: PC unchanged, ir_en=0, bus_oe=0.
5. Drop rst mid-stream, one cycle after ii, before ir_en appears → PC=RESET_PC, inst=0, ir_en never pulses, halted=0.
6. (FETCH_BKPT_EN) bkpt_arm=1, bkpt_addr=4'h9, mi with bus_in=8'h09 → MAR=9, then halted=1 and bkpt_hit=1. The same sequence with bkpt_arm=0 → no halt.
